// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin sharing of one SPI bus between two masters with turnaround gap and stall watchdog
module spi_bus_arbiter #(
  parameter int CS_W = 8,
  parameter int GAP_CYCLES = 4,
  parameter int IDLE_TIMEOUT = 65535
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req0_i,
  output logic            gnt0_o,
  input  logic            sck0_i,
  input  logic            mosi0_i,
  input  logic [CS_W-1:0] cs0_i,
  output logic            miso0_o,
  input  logic            req1_i,
  output logic            gnt1_o,
  input  logic            sck1_i,
  input  logic            mosi1_i,
  input  logic [CS_W-1:0] cs1_i,
  output logic            miso1_o,
  output logic            spi_clk_o,
  output logic            spi_mosi_o,
  output logic [CS_W-1:0] spi_cs_o,
  input  logic            spi_miso_i,
  output logic            timeout_o
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} state_t;
  localparam int IW = IDLE_TIMEOUT > 0 ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IW-1:0] IMAX = IW'(IDLE_TIMEOUT > 0 ? IDLE_TIMEOUT - 1 : 0);
  localparam logic [GW-1:0] GMAX = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  localparam state_t REL = GAP_CYCLES > 0 ? GAP : IDLE;
  state_t state, state_d;
  logic last_q, lock0, lock1, sck0_q, sck1_q, timeout_q;
  logic [GW-1:0] gap_cnt;
  logic [IW-1:0] idle_cnt;
  logic own0, own1, own, own_req, own_idle, fire, ereq0, ereq1;
  assign own0 = state == OWN0;
  assign own1 = state == OWN1;
  assign own = own0 | own1;
  assign gnt0_o = own0;
  assign gnt1_o = own1;
  assign timeout_o = timeout_q;
  assign ereq0 = req0_i & ~lock0;
  assign ereq1 = req1_i & ~lock1;
  assign own_req = own1 ? req1_i : req0_i;
  assign own_idle = own1 ? (sck1_i == sck1_q) && (&cs1_i) : (sck0_i == sck0_q) && (&cs0_i);
  assign fire = (IDLE_TIMEOUT > 0) && own && own_req && own_idle && idle_cnt == IMAX;
  // next-state selection and bus multiplexing from the current owner
  always_comb begin
    state_d = state;
    spi_clk_o = own0 ? sck0_i : own1 ? sck1_i : 1'b0;
    spi_mosi_o = own0 ? mosi0_i : own1 ? mosi1_i : 1'b0;
    spi_cs_o = own0 ? cs0_i : own1 ? cs1_i : '1;
    miso0_o = own0 & spi_miso_i;
    miso1_o = own1 & spi_miso_i;
    case (state)
      IDLE: state_d = ereq0 && (!ereq1 || last_q) ? OWN0 : ereq1 ? OWN1 : IDLE;
      OWN0, OWN1: state_d = !own_req || fire ? REL : state;
      GAP: state_d = gap_cnt == GMAX ? IDLE : GAP;
      default: state_d = IDLE;
    endcase
  end
  // state, fairness pointer, lockouts, gap timer and watchdog counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      last_q <= 1'b1;
      lock0 <= 1'b0;
      lock1 <= 1'b0;
      sck0_q <= 1'b0;
      sck1_q <= 1'b0;
      timeout_q <= 1'b0;
      gap_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      state <= state_d;
      timeout_q <= fire;
      sck0_q <= sck0_i;
      sck1_q <= sck1_i;
      last_q <= state == IDLE && state_d != IDLE ? state_d == OWN1 : last_q;
      lock0 <= fire && own0 ? 1'b1 : !req0_i ? 1'b0 : lock0;
      lock1 <= fire && own1 ? 1'b1 : !req1_i ? 1'b0 : lock1;
      gap_cnt <= state == GAP ? gap_cnt + 1'b1 : '0;
      idle_cnt <= !(own && own_idle) ? '0 : idle_cnt == IMAX ? idle_cnt : idle_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter: directed and randomized checking of spi_bus_arbiter against a transaction-level model
module tb_spi_bus_arbiter;
  localparam int GAP = 4;
  localparam int TO = 16;
  logic clk_i, rst_ni;
  logic req0_i, sck0_i, mosi0_i, req1_i, sck1_i, mosi1_i, spi_miso_i;
  logic [7:0] cs0_i, cs1_i, spi_cs_o;
  logic gnt0_o, gnt1_o, miso0_o, miso1_o, spi_clk_o, spi_mosi_o, timeout_o;
  int total = 0;
  int bad = 0;

  spi_bus_arbiter #(.CS_W(8), .GAP_CYCLES(GAP), .IDLE_TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req0_i(req0_i), .gnt0_o(gnt0_o), .sck0_i(sck0_i), .mosi0_i(mosi0_i), .cs0_i(cs0_i), .miso0_o(miso0_o),
    .req1_i(req1_i), .gnt1_o(gnt1_o), .sck1_i(sck1_i), .mosi1_i(mosi1_i), .cs1_i(cs1_i), .miso1_o(miso1_o),
    .spi_clk_o(spi_clk_o), .spi_mosi_o(spi_mosi_o), .spi_cs_o(spi_cs_o), .spi_miso_i(spi_miso_i),
    .timeout_o(timeout_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // transaction-level model: owner id (-1 = none), remaining gap cycles, stall length
  int m_own = -1;
  int m_gap = 0;
  int m_stall = 0;
  int m_last = 1;
  logic m_to = 1'b0;
  logic m_lock [2];
  logic m_p [2];
  logic m_r [2];
  logic m_s [2];
  logic [7:0] m_c [2];
  logic m_e0, m_e1, m_still;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_own = -1; m_gap = 0; m_stall = 0; m_last = 1; m_to = 1'b0;
      m_lock[0] = 1'b0; m_lock[1] = 1'b0; m_p[0] = 1'b0; m_p[1] = 1'b0;
    end else begin
      m_r[0] = req0_i; m_r[1] = req1_i;
      m_s[0] = sck0_i; m_s[1] = sck1_i;
      m_c[0] = cs0_i; m_c[1] = cs1_i;
      m_to = 1'b0;
      if (m_own >= 0) begin
        m_still = (m_s[m_own] == m_p[m_own]) && (m_c[m_own] == 8'hFF);
        if (!m_r[m_own]) begin
          m_own = -1; m_gap = GAP;
        end else if (m_still && m_stall == TO - 1) begin
          m_lock[m_own] = 1'b1; m_to = 1'b1; m_own = -1; m_gap = GAP;
        end else m_stall = m_still ? m_stall + 1 : 0;
      end else if (m_gap > 0) m_gap--;
      else begin
        m_e0 = m_r[0] && !m_lock[0];
        m_e1 = m_r[1] && !m_lock[1];
        if (m_e0 && m_e1) m_own = 1 - m_last;
        else if (m_e0) m_own = 0;
        else if (m_e1) m_own = 1;
        if (m_own >= 0) begin m_last = m_own; m_stall = 0; end
      end
      if (!m_r[0]) m_lock[0] = 1'b0;
      if (!m_r[1]) m_lock[1] = 1'b0;
      m_p[0] = m_s[0]; m_p[1] = m_s[1];
    end
  end

  // every-cycle comparison of all outputs against the model
  always @(negedge clk_i) begin
    chk("gnt0", 32'(gnt0_o), 32'(m_own == 0));
    chk("gnt1", 32'(gnt1_o), 32'(m_own == 1));
    chk("timeout", 32'(timeout_o), 32'(m_to));
    chk("spi_cs", 32'(spi_cs_o), 32'(m_own == 0 ? cs0_i : m_own == 1 ? cs1_i : 8'hFF));
    chk("spi_clk", 32'(spi_clk_o), 32'(m_own == 0 ? sck0_i : m_own == 1 ? sck1_i : 1'b0));
    chk("spi_mosi", 32'(spi_mosi_o), 32'(m_own == 0 ? mosi0_i : m_own == 1 ? mosi1_i : 1'b0));
    chk("miso0", 32'(miso0_o), 32'(m_own == 0 ? spi_miso_i : 1'b0));
    chk("miso1", 32'(miso1_o), 32'(m_own == 1 ? spi_miso_i : 1'b0));
  end

  int cnt, n, w;
  int exp_w [4];
  logic q0, q1;

  initial begin
    exp_w[0] = 1; exp_w[1] = 0; exp_w[2] = 1; exp_w[3] = 0;
    rst_ni = 1'b0; req0_i = 1'b0; req1_i = 1'b0; sck0_i = 1'b0; sck1_i = 1'b0;
    mosi0_i = 1'b0; mosi1_i = 1'b0; cs0_i = 8'hFF; cs1_i = 8'hFF; spi_miso_i = 1'b0;
    tick(3);
    chk("rst_gnt0", 32'(gnt0_o), 32'd0);
    chk("rst_gnt1", 32'(gnt1_o), 32'd0);
    chk("rst_cs", 32'(spi_cs_o), 32'hFF);
    chk("rst_to", 32'(timeout_o), 32'd0);
    rst_ni = 1'b1;
    tick(2);
    req0_i = 1'b1;
    tick(1);
    chk("lat_gnt0", 32'(gnt0_o), 32'd1);
    cs0_i = 8'hFE; sck0_i = 1'b1; mosi0_i = 1'b1; spi_miso_i = 1'b1;
    #1;
    chk("own_cs", 32'(spi_cs_o), 32'hFE);
    chk("own_clk_hi", 32'(spi_clk_o), 32'd1);
    chk("own_mosi", 32'(spi_mosi_o), 32'd1);
    chk("own_miso0", 32'(miso0_o), 32'd1);
    chk("own_miso1", 32'(miso1_o), 32'd0);
    tick(1);
    sck0_i = 1'b0;
    #1;
    chk("own_clk_lo", 32'(spi_clk_o), 32'd0);
    cs0_i = 8'hFF; req0_i = 1'b0; mosi0_i = 1'b0;
    tick(1);
    chk("rel_gnt0", 32'(gnt0_o), 32'd0);
    tick(6);
    rst_ni = 1'b0;
    tick(1);
    rst_ni = 1'b1;
    tick(1);
    req0_i = 1'b1; req1_i = 1'b1;
    tick(1);
    chk("tie_gnt0", 32'(gnt0_o), 32'd1);
    chk("tie_gnt1", 32'(gnt1_o), 32'd0);
    req0_i = 1'b0;
    tick(1);
    chk("gap_gnt0", 32'(gnt0_o), 32'd0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      cnt += int'(gnt1_o);
      chk("gap_cs", 32'(spi_cs_o), 32'hFF);
    end
    chk("gap_no_gnt1", 32'(cnt), 32'd0);
    tick(1);
    chk("gap_gnt1", 32'(gnt1_o), 32'd1);
    req0_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!gnt0_o && !gnt1_o && n < 20) begin tick(1); n++; end
      w = gnt1_o ? 1 : gnt0_o ? 0 : 9;
      chk("rr_order", 32'(w), 32'(exp_w[k]));
      if (w == 0) req0_i = 1'b0; else req1_i = 1'b0;
      tick(1);
      req0_i = 1'b1; req1_i = 1'b1;
    end
    req0_i = 1'b0; req1_i = 1'b0;
    tick(8);
    req0_i = 1'b1;
    tick(1);
    chk("to_gnt", 32'(gnt0_o), 32'd1);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin tick(1); cnt += int'(timeout_o); end
    chk("to_early", 32'(cnt), 32'd0);
    tick(1);
    chk("to_pulse", 32'(timeout_o), 32'd1);
    chk("to_gnt_drop", 32'(gnt0_o), 32'd0);
    tick(1);
    chk("to_once", 32'(timeout_o), 32'd0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin tick(1); cnt += int'(gnt0_o); end
    chk("lock_hold", 32'(cnt), 32'd0);
    req0_i = 1'b0;
    tick(1);
    req0_i = 1'b1;
    tick(1);
    chk("unlock_gnt", 32'(gnt0_o), 32'd1);
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      cnt += int'(timeout_o);
      if (i % 10 == 9) sck0_i = ~sck0_i;
    end
    chk("toggle_no_to", 32'(cnt), 32'd0);
    chk("toggle_gnt", 32'(gnt0_o), 32'd1);
    req0_i = 1'b0;
    tick(6);
    req0_i = 1'b1;
    tick(1);
    chk("race_gnt", 32'(gnt0_o), 32'd1);
    tick(15);
    req0_i = 1'b0;
    tick(1);
    chk("race_no_to", 32'(timeout_o), 32'd0);
    chk("race_rel", 32'(gnt0_o), 32'd0);
    req0_i = 1'b1;
    tick(5);
    chk("race_regnt", 32'(gnt0_o), 32'd1);
    req0_i = 1'b0;
    tick(8);
    req1_i = 1'b1;
    tick(1);
    chk("ar_gnt1", 32'(gnt1_o), 32'd1);
    cs1_i = 8'hFD;
    #1;
    chk("ar_cs_own", 32'(spi_cs_o), 32'hFD);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("ar_cs", 32'(spi_cs_o), 32'hFF);
    chk("ar_gnt1_off", 32'(gnt1_o), 32'd0);
    cs1_i = 8'hFF; req0_i = 1'b1;
    tick(2);
    rst_ni = 1'b1;
    tick(1);
    chk("ar_tie0", 32'(gnt0_o), 32'd1);
    chk("ar_tie1", 32'(gnt1_o), 32'd0);
    q0 = 1'b0; q1 = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 24) == 0) req0_i = ~req0_i;
      if ($urandom_range(0, 24) == 0) req1_i = ~req1_i;
      if ($urandom_range(0, 39) == 0) q0 = ~q0;
      if ($urandom_range(0, 39) == 0) q1 = ~q1;
      if (!q0) begin
        sck0_i = 1'($urandom); mosi0_i = 1'($urandom);
        cs0_i = $urandom_range(0, 3) == 0 ? 8'($urandom) : 8'hFF;
      end
      if (!q1) begin
        sck1_i = 1'($urandom); mosi1_i = 1'($urandom);
        cs1_i = $urandom_range(0, 3) == 0 ? 8'($urandom) : 8'hFF;
      end
      spi_miso_i = 1'($urandom);
      tick(1);
    end
    req0_i = 1'b0; req1_i = 1'b0;
    tick(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Shares the single board SPI bus (flash SCK/SI/SO plus the flash and SD-card chip selects) between two SPI masters.
- Requester 0 is the SoC SPI master; requester 1 is a secondary engine, e.g. a boot or bitstream loader.
- Grants whole transactions with round-robin fairness and drives all chip selects inactive for a turnaround gap between owners.
- A watchdog reclaims the bus from a stalled owner; sits between fpga_top's SPI pins and the pad assignments.

Parameters:
- CS_W, 8, chip-select vector width (bit0 flash, bit1 SD card).
- GAP_CYCLES, 4, clk_i cycles of forced idle bus between grants; 0 = no gap.
- IDLE_TIMEOUT, 65535, consecutive idle-bus cycles before a grant is revoked; 0 disables the watchdog.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  asynchronous active-low reset
- req0_i  input  1  requester 0 bus request, level
- gnt0_o  output  1  requester 0 grant
- sck0_i  input  1  requester 0 SPI clock
- mosi0_i  input  1  requester 0 MOSI
- cs0_i  input  CS_W  requester 0 chip selects, active-low
- miso0_o  output  1  MISO returned to requester 0
- req1_i, gnt1_o, sck1_i, mosi1_i, cs1_i, miso1_o  same as above for requester 1
- spi_clk_o  output  1  bus SCK
- spi_mosi_o  output  1  bus MOSI
- spi_cs_o  output  CS_W  bus chip selects, active-low
- spi_miso_i  input  1  bus MISO
- timeout_o  output  1  one-cycle pulse when a grant is revoked by the watchdog

Behaviour:
- Clock and reset: one clock, clk_i; reset is asynchronous and active-low (rst_ni).
- Reset state:
  - state=IDLE, gnt0_o=gnt1_o=0, timeout_o=0.
  - spi_cs_o all 1, spi_clk_o=0, spi_mosi_o=0.
  - Round-robin pointer last_q=1, so requester 0 wins the first tie.
  - Lockout masks lock0/lock1=0; gap and idle counters=0.
- States: IDLE, OWN0, OWN1, GAP. Grants are registered decodes of the state: gnt0_o=(state==OWN0), gnt1_o=(state==OWN1).
- IDLE:
  - Effective requests: ereq0 = req0_i & ~lock0; ereq1 = req1_i & ~lock1.
  - Only one effective request: go to its OWN state next cycle.
  - Both: grant the requester != last_q.
  - last_q is updated on entering OWNx.
  - Grant latency from req assertion in IDLE: 1 cycle.
- OWNx:
  - Bus outputs are a combinational mux of requester x's sck/mosi/cs.
  - miso_x_o = spi_miso_i; the other requester's miso_o = 0.
  - The requester must hold its cs lines high until it sees gnt, and must hold req until its transaction ends with cs high.
  - req_x low: go to GAP if GAP_CYCLES>0, else IDLE; gnt drops in the next cycle.
- Outside OWN states: spi_cs_o all 1, spi_clk_o=0, spi_mosi_o=0, both miso_o=0.
- GAP:
  - Counts GAP_CYCLES cycles, then goes to IDLE.
  - Requests are ignored during GAP; no grant is possible sooner than GAP_CYCLES+1 cycles after release.
- Watchdog (IDLE_TIMEOUT>0, OWN states only):
  - idle_cnt increments on each cycle where the owner's sck equals its previous-cycle value AND its cs is all 1.
  - Any sck change or any cs bit low clears idle_cnt; entering OWN also clears it.
  - When idle_cnt reaches IDLE_TIMEOUT-1 with the owner still idle: go to GAP (or IDLE if GAP_CYCLES=0), pulse timeout_o for 1 cycle, set lock_x.
  - idle_cnt saturates and never wraps. Counter width is clog2(IDLE_TIMEOUT+1).
- Lockout: lock_x clears on the first cycle req_x_i is sampled low. A timed-out requester is therefore not re-granted until it drops and re-raises req.
- Simultaneous events:
  - Owner drops req on the same cycle the timeout would fire: treat as a normal release; no timeout pulse, no lock.
  - The other requester raising req while the bus is owned: waits; it is served next after GAP.
- Reset mid-transaction: all outputs return to reset values asynchronously, so spi_cs_o goes all-high immediately.

Test Plan:
- Only req0_i rises at t0 → gnt0_o=1 at t0+1. Drive cs0_i=8'hFE with sck0 toggling → spi_cs_o=8'hFE, spi_clk_o follows sck0_i, miso0_o=spi_miso_i, miso1_o=0.
- req0 and req1 both rise in the same cycle after reset → requester 0 granted. Req0 released → spi_cs_o=8'hFF for 4 cycles (GAP) → gnt1_o=1 on the 5th cycle after gnt0 drops.
- Requester 1 holds req continuously and releases/re-requests back-to-back while req0 stays high → grants alternate 0,1,0,1; neither requester is granted twice in a row.
- IDLE_TIMEOUT=16: owner 0 holds req with cs=FF and sck static → timeout_o pulses exactly once 16 cycles after the grant, gnt0_o drops, then the GAP follows. Req0 held high → no re-grant. Req0 low for 1 cycle then high → granted after GAP.
- Owner toggles sck every 10 cycles with IDLE_TIMEOUT=16 → no timeout across 1000 cycles. Owner drops req on the exact timeout cycle → timeout_o stays 0 and a later re-request is granted without lockout.
- rst_ni asserted low while owner 1 drives cs1=8'hFD → spi_cs_o=8'hFF and gnt1_o=0 immediately. After deassertion, a tie between both requesters goes to requester 0.
